mlp_forward: RTL

//  Sequential forward pass of the 16-input, N-hidden, 1-output O/X detector MLP.

---
 rtl/mlp_forward_pkg.sv | 35 +++
 rtl/mlp_forward_if.sv | 30 +++
 rtl/mlp_forward_hidden_neuron.sv | 30 +++
 rtl/mlp_forward.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mlp_forward_pkg.sv
// Shared widths, FSM state codes and saturation helper for the MLP forward pass.
package mlp_forward_pkg;

    localparam int unsigned W_DEF    = 8;
    localparam int unsigned N_DEF    = 8;
    localparam int unsigned FRAC_DEF = 6;
    localparam int          T_POS_DEF = 32;
    localparam int          T_NEG_DEF = -32;

    localparam int unsigned X_W    = 16;
    localparam int unsigned HRAW_W = W_DEF + 5;
    localparam int unsigned ACC_W  = 2 * W_DEF + 6 + $clog2(N_DEF);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HID  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_to(input logic signed [31:0] v,
                                                  input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mlp_forward_if.sv
// Request/result bundle between a pass initiator and mlp_forward.
interface mlp_forward_if
    import mlp_forward_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned N = N_DEF
);
    logic                   start;
    logic                   train_en;
    logic [X_W-1:0]         x_in;
    logic                   label;
    logic [X_W-1:0]         x;
    logic [N*(W+5)-1:0]     h_act_bus;
    logic [W-1:0]           y;
    logic [W-1:0]           err;
    logic                   pred;
    logic                   busy;
    logic                   done;
    logic                   learn;

    modport master (
        output start, train_en, x_in, label,
        input  x, h_act_bus, y, err, pred, busy, done, learn
    );

    modport slave (
        input  start, train_en, x_in, label,
        output x, h_act_bus, y, err, pred, busy, done, learn
    );
endinterface

// File: rtl/mlp_forward_hidden_neuron.sv
// One hidden neuron: 17-term signed sum of bias and +/- weights, then ReLU.
module mlp_forward_hidden_neuron
    import mlp_forward_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [X_W*W-1:0] w_row,
    input  logic [W-1:0]     bias,
    input  logic [X_W-1:0]   x,
    output logic [W+4:0]     h_act_c
);
    localparam int unsigned HW = W + 5;

    logic signed [HW-1:0] pre_c;

    // Pixel 1 adds the weight, pixel 0 subtracts it; W+5 bits cannot overflow.
    always_comb begin
        pre_c = HW'($signed(bias));
        for (int j = 0; j < int'(X_W); j++) begin
            if (x[j]) begin
                pre_c = pre_c + HW'($signed(w_row[j*W +: W]));
            end else begin
                pre_c = pre_c - HW'($signed(w_row[j*W +: W]));
            end
        end
    end

    assign h_act_c = pre_c[HW-1] ? '0 : pre_c;

endmodule

// File: rtl/mlp_forward.sv
// Sequential forward pass: one hidden neuron per cycle, then one output MAC per cycle.
module mlp_forward
    import mlp_forward_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned N     = N_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int          T_POS = T_POS_DEF,
    parameter int          T_NEG = T_NEG_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mlp_forward_if.slave         bus,
    input  logic [N*W-1:0]       w_o_bus,
    input  logic [W-1:0]         b_o,
    input  logic [N*X_W*W-1:0]   w_h_bus,
    input  logic [N*W-1:0]       b_h_bus
);
    localparam int unsigned HW    = W + 5;
    localparam int unsigned AW    = 2 * W + 6 + $clog2(N);
    localparam int unsigned CNT_W = $clog2(N);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [X_W-1:0]         x_q, x_d;
    logic                   label_q, label_d;
    logic                   train_q, train_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [N*HW-1:0]        h_act_q, h_act_d;
    logic [W-1:0]           y_q, y_d;
    logic [W-1:0]           err_q, err_d;
    logic                   pred_q, pred_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   learn_q, learn_d;

    int unsigned              idx_c;
    logic [X_W*W-1:0]         w_row_c;
    logic [W-1:0]             b_h_c;
    logic [HW-1:0]            hid_c;
    logic signed [HW+W-1:0]   prod_c;
    logic signed [AW:0]       y_raw_c;
    logic signed [W-1:0]      tgt_c;
    logic signed [W:0]        diff_c;

    assign idx_c   = 32'(cnt_q);
    assign w_row_c = w_h_bus[idx_c*(X_W*W) +: X_W*W];
    assign b_h_c   = b_h_bus[idx_c*W +: W];
    assign prod_c  = $signed(h_act_q[idx_c*HW +: HW]) * $signed(w_o_bus[idx_c*W +: W]);
    assign y_raw_c = (AW+1)'(acc_q >>> FRAC) + (AW+1)'($signed(b_o));
    assign tgt_c   = label_q ? W'(T_POS) : W'(T_NEG);

    mlp_forward_hidden_neuron #(.W(W)) u_hidden (
        .w_row   (w_row_c),
        .bias    (b_h_c),
        .x       (x_q),
        .h_act_c (hid_c)
    );

    // Next-state, counter, datapath and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        label_d = label_q;
        train_d = train_q;
        acc_d   = acc_q;
        h_act_d = h_act_q;
        y_d     = y_q;
        err_d   = err_q;
        pred_d  = pred_q;
        done_d  = 1'b0;
        learn_d = 1'b0;
        diff_c  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_HID;
                    cnt_d   = '0;
                    acc_d   = '0;
                    x_d     = bus.x_in;
                    label_d = bus.label;
                    train_d = bus.train_en;
                end
            end
            S_HID: begin
                h_act_d[idx_c*HW +: HW] = hid_c;
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                acc_d = acc_q + AW'(prod_c);
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                y_d     = W'(sat_to(32'(y_raw_c), W));
                diff_c  = (W+1)'(tgt_c) - (W+1)'($signed(y_d));
                err_d   = W'(sat_to(32'(diff_c), W));
                pred_d  = ~y_d[W-1];
                done_d  = 1'b1;
                learn_d = train_q;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            label_q <= 1'b0;
            train_q <= 1'b0;
            acc_q   <= '0;
            h_act_q <= '0;
            y_q     <= '0;
            err_q   <= '0;
            pred_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            learn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            label_q <= label_d;
            train_q <= train_d;
            acc_q   <= acc_d;
            h_act_q <= h_act_d;
            y_q     <= y_d;
            err_q   <= err_d;
            pred_q  <= pred_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            learn_q <= learn_d;
        end
    end

    assign bus.x         = x_q;
    assign bus.h_act_bus = h_act_q;
    assign bus.y         = y_q;
    assign bus.err       = err_q;
    assign bus.pred      = pred_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.learn     = learn_q;

endmodule
